// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data memory access unit.
package dmem_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned BE_W            = XLEN / 8;

  // Access size as encoded on SizeM.
  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  // Bus transaction FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Registered request payload driven onto the data memory bus.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for data memory accesses.
//   Store side: addr_lo/size/wdata -> wdata_rep_c, be_c, misalign_c
//   Load side : ld_addr_lo/ld_size/ld_signed/rdata -> rdata_ext_c
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  size_e           size,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] wdata_rep_c,
  output logic [BE_W-1:0] be_c,
  output logic            misalign_c,
  input  logic [1:0]      ld_addr_lo,
  input  size_e           ld_size,
  input  logic            ld_signed,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] rdata_ext_c
);

  logic [XLEN-1:0] rdata_sh;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Store lane replication, byte enables and alignment check.
  always_comb begin
    wdata_rep_c = wdata;
    be_c        = 4'b1111;
    misalign_c  = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata_rep_c = {4{wdata[7:0]}};
        be_c        = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata_rep_c = {2{wdata[15:0]}};
        be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign_c  = addr_lo[0];
      end
      SZ_WORD: begin
        misalign_c  = |addr_lo;
      end
      default: begin
        be_c        = 4'b0000;
        misalign_c  = 1'b1;
      end
    endcase
  end

  // Load lane extraction and zero/sign extension.
  always_comb begin
    rdata_sh    = rdata >> {ld_addr_lo, 3'b000};
    byte_sel    = rdata_sh[7:0];
    half_sel    = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext_c = rdata;
    case (ld_size)
      SZ_BYTE: rdata_ext_c = {{24{ld_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata_ext_c = {{16{ld_signed & half_sel[15]}}, half_sel};
      default: rdata_ext_c = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// M-stage data access unit: issues one registered request per load/store,
// waits for mem_ack (bounded by TIMEOUT), and returns aligned load data.
//   Pipeline side: MemReadM/MemWriteM/SizeM/LoadSignedM/ALUResultM/WriteDataM in,
//                  ReadDataM/StallMem/MisalignM/BusErrM out.
//   Bus side     : mem_req/mem_we/mem_addr/mem_be/mem_wdata out, mem_ack/mem_rdata in.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [1:0]      SizeM,
  input  logic            LoadSignedM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallMem,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  bus_req_t        bus_q;
  logic            req_q;
  logic [XLEN-1:0] rdata_q;
  logic            buserr_q;
  logic [1:0]      ld_lo_q;
  size_e           ld_size_q;
  logic            ld_signed_q;

  logic            access_c;
  logic            issue_c;
  logic            last_c;
  logic [XLEN-1:0] wdata_rep_c;
  logic [BE_W-1:0] be_c;
  logic            misalign_c;
  logic [XLEN-1:0] rdata_ext_c;

  dmem_lane_align u_lane (
    .addr_lo     (ALUResultM[1:0]),
    .size        (size_e'(SizeM)),
    .wdata       (WriteDataM),
    .wdata_rep_c (wdata_rep_c),
    .be_c        (be_c),
    .misalign_c  (misalign_c),
    .ld_addr_lo  (ld_lo_q),
    .ld_size     (ld_size_q),
    .ld_signed   (ld_signed_q),
    .rdata       (mem_rdata),
    .rdata_ext_c (rdata_ext_c)
  );

  assign access_c = MemReadM | MemWriteM;
  assign issue_c  = (state_q == ST_IDLE) & access_c & ~misalign_c;
  assign last_c   = (cnt_q == CNT_LAST);

  // Stall and misalign are same-cycle responses to the M-stage instruction;
  // gated by reset so every output reads 0 while reset is held.
  assign StallMem  = reset & (issue_c | (state_q == ST_REQ));
  assign MisalignM = reset & (state_q == ST_IDLE) & access_c & misalign_c;

  assign ReadDataM = rdata_q;
  assign BusErrM   = buserr_q;
  assign mem_req   = req_q;
  assign mem_we    = bus_q.we;
  assign mem_addr  = bus_q.addr;
  assign mem_be    = bus_q.be;
  assign mem_wdata = bus_q.wdata;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue_c) state_d = ST_REQ;
      ST_REQ:  if (mem_ack || last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Bus, counter, capture and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      bus_q       <= '0;
      req_q       <= 1'b0;
      rdata_q     <= '0;
      buserr_q    <= 1'b0;
      ld_lo_q     <= 2'b00;
      ld_size_q   <= SZ_BYTE;
      ld_signed_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_c) begin
            req_q       <= 1'b1;
            bus_q       <= '{we:    MemWriteM,
                             addr:  {ALUResultM[XLEN-1:2], 2'b00},
                             be:    be_c,
                             wdata: MemWriteM ? wdata_rep_c : '0};
            ld_lo_q     <= ALUResultM[1:0];
            ld_size_q   <= size_e'(SizeM);
            ld_signed_q <= LoadSignedM;
            cnt_q       <= '0;
          end
        end
        ST_REQ: begin
          // Ack takes priority over timeout on the final wait cycle.
          if (mem_ack) begin
            req_q    <= 1'b0;
            bus_q    <= '0;
            rdata_q  <= rdata_ext_c;
            buserr_q <= 1'b0;
            cnt_q    <= '0;
          end else if (last_c) begin
            req_q    <= 1'b0;
            bus_q    <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Result is presented for exactly the DONE cycle.
          rdata_q  <= '0;
          buserr_q <= 1'b0;
        end
        default: begin
          req_q    <= 1'b0;
          bus_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver queues expected bus
// requests and responses, a responder acks after a programmed delay, and
// a monitor compares whenever a request starts or a response is presented.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic        MemReadM, MemWriteM, LoadSignedM;
  logic [1:0]  SizeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem, MisalignM, BusErrM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  dmem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .SizeM(SizeM),
    .LoadSignedM(LoadSignedM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallMem(StallMem), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        mis;
    logic        err;
    logic [31:0] rd;
    int          stall;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          ack_delay = 0;
  logic [31:0] rdata_cfg = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bus responder: acks on the ack_delay-th REQ cycle (never if negative).
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (ack_delay >= 0 && wcnt == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = rdata_cfg;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 32'h0BAD0BAD;
        end
        wcnt++;
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: checks each new request and each presented response.
  initial begin
    logic      prev_stall, prev_req;
    int        stall_cnt;
    bus_exp_t  eb;
    resp_exp_t er;
    prev_stall = 1'b0;
    prev_req = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
        prev_req = 1'b0;
        stall_cnt = 0;
      end else begin
        if (mem_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            chk32("bus_unexpected_req", 32'(mem_req), 32'h0);
          end else begin
            eb = bus_q.pop_front();
            chk32("mem_we", 32'(mem_we), 32'(eb.we));
            chk32("mem_addr", mem_addr, eb.addr);
            chk32("mem_be", 32'(mem_be), 32'(eb.be));
            chk32("mem_wdata", mem_wdata, eb.wdata);
          end
        end
        if (StallMem) stall_cnt++;
        if (MisalignM || (prev_stall && !StallMem)) begin
          if (resp_q.size() == 0) begin
            chk32("resp_unexpected", 32'(MisalignM), 32'h0);
          end else begin
            er = resp_q.pop_front();
            chk32("MisalignM", 32'(MisalignM), 32'(er.mis));
            chk32("BusErrM", 32'(BusErrM), 32'(er.err));
            chk32("ReadDataM", ReadDataM, er.rd);
            chk_int("stall_cycles", stall_cnt, er.stall);
          end
          stall_cnt = 0;
        end else if (BusErrM) begin
          chk32("BusErrM_spurious", 32'(BusErrM), 32'h0);
        end
        prev_stall = StallMem;
        prev_req = mem_req;
      end
    end
  end

  task automatic set_idle();
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    SizeM = 2'b00;
    LoadSignedM = 1'b0;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
  endtask

  // One M-stage instruction held until the pipeline advances.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int dly,
                        input logic mis, input logic err, input logic [31:0] exp_rd,
                        input int exp_stall, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int n;
    resp_exp_t er;
    bus_exp_t  eb;
    if (!mis) begin
      eb.we = wr; eb.addr = exp_addr; eb.be = exp_be; eb.wdata = exp_wdata;
      bus_q.push_back(eb);
    end
    er.mis = mis; er.err = err; er.rd = exp_rd; er.stall = exp_stall;
    resp_q.push_back(er);
    @(posedge clk);
    #1;
    MemReadM = rd; MemWriteM = wr; SizeM = sz; LoadSignedM = sgn;
    ALUResultM = addr; WriteDataM = wd;
    ack_delay = dly; rdata_cfg = rdat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (StallMem && n < 64);
    if (n >= 64) chk32("stall_bound", 32'(StallMem), 32'h0);
    @(posedge clk);
    #1;
    set_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    set_idle();
    #2;
    chk32("rst_mem_req", 32'(mem_req), 32'h0);
    chk32("rst_StallMem", 32'(StallMem), 32'h0);
    chk32("rst_ReadDataM", ReadDataM, 32'h0);
    chk32("rst_mem_be", 32'(mem_be), 32'h0);
    chk32("rst_BusErrM", 32'(BusErrM), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Non-memory instruction: no stall, no misalign even with an odd address.
    @(posedge clk);
    #1;
    SizeM = 2'b10; ALUResultM = 32'h101;
    #1;
    chk32("nomem_StallMem", 32'(StallMem), 32'h0);
    chk32("nomem_MisalignM", 32'(MisalignM), 32'h0);
    set_idle();

    //     rd    wr    sz     sgn   addr          wdata         rdata         dly mis   err   exp_rd        stall exp_addr     be       exp_wdata
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100,      32'h0,        32'hDEADBEEF, 0,  1'b0, 1'b0, 32'hDEADBEEF, 2,    32'h100,     4'b1111, 32'h0);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103,      32'h0,        32'h80000000, 0,  1'b0, 1'b0, 32'hFFFFFF80, 2,    32'h100,     4'b1000, 32'h0);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103,      32'h0,        32'h80000000, 0,  1'b0, 1'b0, 32'h00000080, 2,    32'h100,     4'b1000, 32'h0);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h102,      32'h1234ABCD, 32'h0,        0,  1'b0, 1'b0, 32'h0,        2,    32'h100,     4'b1100, 32'hABCDABCD);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101,      32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h0,        0,    32'h0,       4'b0000, 32'h0);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h103,      32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h0,        0,    32'h0,       4'b0000, 32'h0);
    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h200,      32'hFFFFFFFF, 32'h0,        0,  1'b1, 1'b0, 32'h0,        0,    32'h0,       4'b0000, 32'h0);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h201,      32'h00000055, 32'h0,        2,  1'b0, 1'b0, 32'h0,        4,    32'h200,     4'b0010, 32'h55555555);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h106,      32'h0,        32'h80011234, 1,  1'b0, 1'b0, 32'hFFFF8001, 3,    32'h104,     4'b1100, 32'h0);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h104,      32'h0,        32'hCAFE8001, 0,  1'b0, 1'b0, 32'h00008001, 2,    32'h104,     4'b0011, 32'h0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h300,      32'h01020304, 32'h0,        0,  1'b0, 1'b0, 32'h0,        2,    32'h300,     4'b1111, 32'h01020304);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h101,      32'h0,        32'h00007F00, 0,  1'b0, 1'b0, 32'h0000007F, 2,    32'h100,     4'b0010, 32'h0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h500,      32'h0,        32'h12345678, -1, 1'b0, 1'b1, 32'h0,        17,   32'h500,     4'b1111, 32'h0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h504,      32'h0,        32'hA5A55A5A, 15, 1'b0, 1'b0, 32'hA5A55A5A, 17,   32'h504,     4'b1111, 32'h0);

    // Reset asserted in the third REQ wait cycle of a never-acked load.
    begin
      bus_exp_t eb;
      eb.we = 1'b0; eb.addr = 32'h400; eb.be = 4'b1111; eb.wdata = 32'h0;
      bus_q.push_back(eb);
    end
    @(posedge clk);
    #1;
    MemReadM = 1'b1; SizeM = 2'b10; ALUResultM = 32'h400; ack_delay = -1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk32("midrst_mem_req", 32'(mem_req), 32'h0);
    chk32("midrst_StallMem", 32'(StallMem), 32'h0);
    chk32("midrst_mem_addr", mem_addr, 32'h0);
    chk32("midrst_mem_be", 32'(mem_be), 32'h0);
    set_idle();
    @(posedge clk);
    #1 reset = 1'b1;
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h404,      32'h0,        32'h13579BDF, 0,  1'b0, 1'b0, 32'h13579BDF, 2,    32'h404,     4'b1111, 32'h0);

    repeat (4) @(posedge clk);
    chk_int("resp_queue_drained", resp_q.size(), 0);
    chk_int("bus_queue_drained", bus_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
